// File: rtl/axi_beat_address_expander.sv
// -----------------------------------------------------------------------------
// axi_beat_address_expander
//
// AXI4 address-channel responder. Accepts one AR/AW burst (FIXED, INCR or WRAP)
// at a time and expands it into one registered beat per cycle: byte address,
// beat index, last flag and burst ID. The beat channel is a valid/ready pair;
// outputs hold while the consumer stalls and advance only on a handshake.
//
// Optional feature (compile-time macro AXI_BEAT_ADDR_SKID_EN):
//   defined   - one-entry burst buffer; axready stays high during a burst while
//               the buffer is empty, so back-to-back bursts stream without a
//               bubble.
//   undefined - axready is high only in IDLE; one idle cycle between bursts.
//
// Parameters:
//   ADDR_WIDTH  address width in bits
//   ID_WIDTH    AxID width
//   MAX_AxSIZE  largest legal axsize; larger requests are clamped (protoErr)
//
// Ports:
//   aclk, resetn          clock (rising edge), asynchronous active-low reset
//   axid/axaddr/axlen/    burst request (ID, start address, beats-1,
//   axsize/axburst        log2 bytes per beat, burst type)
//   axvalid/axready       address handshake (axready registered)
//   beatId/beatAddr/      current beat: ID, byte address, index 0..axlen,
//   beatIndex/beatLast    final-beat flag
//   beatValid/beatReady   beat handshake
//   busy                  burst in progress (or buffered burst pending)
//   protoErr              one-cycle pulse after accepting a reserved burst
//                         type, an illegal WRAP length or a clamped axsize
// -----------------------------------------------------------------------------
module axi_beat_address_expander #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_AxSIZE = 3
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [ID_WIDTH-1:0]   axid,
  input  logic [ADDR_WIDTH-1:0] axaddr,
  input  logic [7:0]            axlen,
  input  logic [2:0]            axsize,
  input  logic [1:0]            axburst,
  input  logic                  axvalid,
  output logic                  axready,
  output logic [ID_WIDTH-1:0]   beatId,
  output logic [ADDR_WIDTH-1:0] beatAddr,
  output logic [7:0]            beatIndex,
  output logic                  beatLast,
  output logic                  beatValid,
  input  logic                  beatReady,
  output logic                  busy,
  output logic                  protoErr
);

  localparam logic [2:0]            MaxSize = 3'(MAX_AxSIZE);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1'b1);

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_WRAP  = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Everything needed to generate the remaining beats of one burst.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    mode_e                 mode;
  } burst_t;

  // Address of the beat following 'addr'. INCR re-aligns to the stride so an
  // unaligned start only affects beat 0. WRAP keeps the bits above the wrap
  // window and lets the bits inside it roll over.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input mode_e                 mode,
    input logic [2:0]            size,
    input logic [7:0]            len
  );
    logic [ADDR_WIDTH-1:0] stride;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] result;
    stride    = AddrOne << size;
    wrap_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - AddrOne;
    case (mode)
      MODE_FIXED: result = addr;
      MODE_WRAP:  result = (addr & ~wrap_mask) | ((addr + stride) & wrap_mask);
      default:    result = (addr & ~(stride - AddrOne)) + stride;
    endcase
    return result;
  endfunction

  state_e state_q, state_d;
  burst_t act_q, act_d;
  burst_t in_s;
  logic [7:0] index_q, index_d;
  logic valid_q, valid_d;
  logic last_q, last_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic err_q, err_d;
  logic clamp_s, bad_burst_s, wrap_len_ok_s;
  logic accept_s, hs_s, last_hs_s;
`ifdef AXI_BEAT_ADDR_SKID_EN
  burst_t buf_q, buf_d;
  logic   buf_full_q, buf_full_d;
`endif

  // Decode the incoming request: clamp the size, fall back to INCR for
  // reserved types and WRAP lengths that are not 2, 4, 8 or 16 beats.
  always_comb begin
    in_s          = '0;
    in_s.id       = axid;
    in_s.addr     = axaddr;
    in_s.len      = axlen;
    clamp_s       = (axsize > MaxSize);
    wrap_len_ok_s = (axlen == 8'd1) || (axlen == 8'd3) ||
                    (axlen == 8'd7) || (axlen == 8'd15);
    bad_burst_s   = 1'b0;
    if (clamp_s) begin
      in_s.size = MaxSize;
    end else begin
      in_s.size = axsize;
    end
    case (axburst)
      2'd0: in_s.mode = MODE_FIXED;
      2'd1: in_s.mode = MODE_INCR;
      2'd2: begin
        if (wrap_len_ok_s) begin
          in_s.mode = MODE_WRAP;
        end else begin
          in_s.mode   = MODE_INCR;
          bad_burst_s = 1'b1;
        end
      end
      default: begin
        in_s.mode   = MODE_INCR;
        bad_burst_s = 1'b1;
      end
    endcase
  end

  assign accept_s  = axvalid && ready_q;
  assign hs_s      = valid_q && beatReady;
  assign last_hs_s = hs_s && (index_q == act_q.len);

  // Next-state logic: burst FSM, beat advance and optional burst buffer.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    index_d = index_q;
    valid_d = valid_q;
`ifdef AXI_BEAT_ADDR_SKID_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
`endif
    if (accept_s) begin
      err_d = clamp_s || bad_burst_s;
    end else begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          act_d   = in_s;
          index_d = 8'd0;
          valid_d = 1'b1;
          state_d = ST_BURST;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_BURST: begin
        if (last_hs_s) begin
`ifdef AXI_BEAT_ADDR_SKID_EN
          // A request accepted in the same cycle can only arrive with an
          // empty buffer, so it bypasses the buffer entirely.
          if (accept_s) begin
            act_d   = in_s;
            index_d = 8'd0;
          end else if (buf_full_q) begin
            act_d      = buf_q;
            index_d    = 8'd0;
            buf_full_d = 1'b0;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
`else
          valid_d = 1'b0;
          state_d = ST_IDLE;
`endif
        end else begin
          if (hs_s) begin
            index_d    = index_q + 8'd1;
            act_d.addr = next_addr(act_q.addr, act_q.mode, act_q.size, act_q.len);
          end else begin
            index_d = index_q;
          end
`ifdef AXI_BEAT_ADDR_SKID_EN
          if (accept_s) begin
            buf_d      = in_s;
            buf_full_d = 1'b1;
          end else begin
            buf_full_d = buf_full_q;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    last_d = valid_d && (index_d == act_d.len);
`ifdef AXI_BEAT_ADDR_SKID_EN
    ready_d = !buf_full_d;
    busy_d  = (state_d == ST_BURST) || buf_full_d;
`else
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_BURST);
`endif
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      index_q <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef AXI_BEAT_ADDR_SKID_EN
  // Pending-burst buffer.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`endif

  assign axready   = ready_q;
  assign beatId    = act_q.id;
  assign beatAddr  = act_q.addr;
  assign beatIndex = index_q;
  assign beatLast  = last_q;
  assign beatValid = valid_q;
  assign busy      = busy_q;
  assign protoErr  = err_q;

endmodule

// File: tb/tb_axi_beat_address_expander.sv
module tb_axi_beat_address_expander;

  localparam int MAX_SZ = 3;

  logic        aclk;
  logic        resetn;
  logic [7:0]  axid;
  logic [31:0] axaddr;
  logic [7:0]  axlen;
  logic [2:0]  axsize;
  logic [1:0]  axburst;
  logic        axvalid;
  logic        axready;
  logic [7:0]  beatId;
  logic [31:0] beatAddr;
  logic [7:0]  beatIndex;
  logic        beatLast;
  logic        beatValid;
  logic        beatReady;
  logic        busy;
  logic        protoErr;

  axi_beat_address_expander #(
    .ADDR_WIDTH(32),
    .ID_WIDTH  (8),
    .MAX_AxSIZE(MAX_SZ)
  ) dut (
    .aclk     (aclk),
    .resetn   (resetn),
    .axid     (axid),
    .axaddr   (axaddr),
    .axlen    (axlen),
    .axsize   (axsize),
    .axburst  (axburst),
    .axvalid  (axvalid),
    .axready  (axready),
    .beatId   (beatId),
    .beatAddr (beatAddr),
    .beatIndex(beatIndex),
    .beatLast (beatLast),
    .beatValid(beatValid),
    .beatReady(beatReady),
    .busy     (busy),
    .protoErr (protoErr)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } burst_t;

  int n_checks = 0;
  int n_fail   = 0;
  int gcyc     = 0;

  burst_t      stim_q[$];
  logic [31:0] obs_addr[$];
  logic [7:0]  obs_idx[$];
  logic        obs_last[$];
  logic [7:0]  obs_id[$];
  int          obs_cyc[$];
  int          acc_cyc[$];
  int          err_cyc[$];
  int          hold_viol;
  int          busy_bad;

  logic [31:0] exp_addr[$];
  logic [7:0]  exp_idx[$];
  logic        exp_last[$];
  logic [7:0]  exp_id[$];
  bit          exp_err[$];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic burst_t mk(input logic [7:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
    burst_t t;
    t.id = id; t.addr = addr; t.len = len; t.size = size; t.burst = burst;
    return t;
  endfunction

  // Reference model: expected beats straight from the burst rules.
  task automatic build_expected();
    exp_addr.delete(); exp_idx.delete(); exp_last.delete(); exp_id.delete(); exp_err.delete();
    foreach (stim_q[b]) begin
      burst_t t;
      int sz;
      int kind;
      bit wrap_ok;
      longint unsigned stride, w, base, a;
      t       = stim_q[b];
      sz      = (int'(t.size) > MAX_SZ) ? MAX_SZ : int'(t.size);
      stride  = longint'(1) << sz;
      wrap_ok = t.len inside {8'd1, 8'd3, 8'd7, 8'd15};
      kind    = (t.burst == 2'd0) ? 0 : ((t.burst == 2'd2 && wrap_ok) ? 2 : 1);
      exp_err.push_back((int'(t.size) > MAX_SZ) || (t.burst == 2'd3) || (t.burst == 2'd2 && !wrap_ok));
      w    = (longint'(t.len) + 1) * stride;
      base = t.addr - (t.addr % w);
      for (int k = 0; k <= int'(t.len); k++) begin
        if (kind == 0) a = t.addr;
        else if (kind == 1) a = (k == 0) ? t.addr : (t.addr / stride) * stride + longint'(k) * stride;
        else a = base + ((t.addr - base) + longint'(k) * stride) % w;
        exp_addr.push_back(32'(a));
        exp_idx.push_back(8'(k));
        exp_last.push_back(k == int'(t.len));
        exp_id.push_back(t.id);
      end
    end
  endtask

  // Drives stim_q through the address channel and records every beat
  // handshake; all decisions and samples are made on the falling edge.
  task automatic run_bursts(input int ready_pct, input bit idle_gaps,
                            input int max_cycles, output bit timed_out);
    int total = 0, issued = 0, cyc = 0, wait_cnt = 0;
    bit stalled = 0;
    logic [31:0] s_addr;
    logic [7:0]  s_idx, s_id;
    logic        s_last;
    obs_addr.delete(); obs_idx.delete(); obs_last.delete(); obs_id.delete(); obs_cyc.delete();
    acc_cyc.delete(); err_cyc.delete();
    hold_viol = 0; busy_bad = 0;
    foreach (stim_q[i]) total += int'(stim_q[i].len) + 1;
    if (idle_gaps) wait_cnt = $urandom_range(0, 2);
    while (obs_addr.size() < total && cyc < max_cycles) begin
      @(negedge aclk);
      cyc++; gcyc++;
      if (protoErr) err_cyc.push_back(gcyc);
      if (stalled && (!beatValid || beatAddr !== s_addr || beatIndex !== s_idx ||
                      beatId !== s_id || beatLast !== s_last)) hold_viol++;
      if (issued < stim_q.size() && wait_cnt == 0) begin
        axvalid = 1'b1;
        axid    = stim_q[issued].id;
        axaddr  = stim_q[issued].addr;
        axlen   = stim_q[issued].len;
        axsize  = stim_q[issued].size;
        axburst = stim_q[issued].burst;
      end else begin
        axvalid = 1'b0;
        if (wait_cnt > 0) wait_cnt--;
      end
      if (axvalid && axready) begin
        acc_cyc.push_back(gcyc);
        issued++;
        if (idle_gaps) wait_cnt = $urandom_range(0, 2);
      end
      beatReady = ($urandom_range(0, 99) < ready_pct);
      if (beatValid && beatReady) begin
        obs_addr.push_back(beatAddr); obs_idx.push_back(beatIndex);
        obs_last.push_back(beatLast); obs_id.push_back(beatId); obs_cyc.push_back(gcyc);
        if (!busy) busy_bad++;
        stalled = 0;
      end else if (beatValid) begin
        stalled = 1; s_addr = beatAddr; s_idx = beatIndex; s_id = beatId; s_last = beatLast;
      end else begin
        stalled = 0;
      end
    end
    @(negedge aclk);
    gcyc++;
    if (protoErr) err_cyc.push_back(gcyc);
    axvalid   = 1'b0;
    beatReady = 1'b0;
    timed_out = (obs_addr.size() < total);
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if (axready !== 1'b0 || beatValid !== 1'b0 || beatLast !== 1'b0 || beatIndex !== 8'd0 ||
        beatAddr !== 32'd0 || beatId !== 8'd0 || busy !== 1'b0 || protoErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b v=%b last=%b idx=%0d addr=%h id=%h busy=%b err=%b, required all zero",
               axready, beatValid, beatLast, beatIndex, beatAddr, beatId, busy, protoErr);
    end
    @(negedge aclk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (axready !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready: got %b required 0", axready); end
    @(negedge aclk);
    n_checks++;
    if (axready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", axready); end
    n_checks++;
    if (busy !== 1'b0 || beatValid !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b valid=%b required 0 0", busy, beatValid);
    end
  endtask

  task automatic test_incr();
    logic [31:0] exp_a[4];
    bit to;
    exp_a = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
    stim_q.delete();
    stim_q.push_back(mk(8'h11, 32'h1000, 8'd3, 3'd3, 2'd1));
    run_bursts(100, 0, 200, to);
    n_checks++;
    if (obs_addr.size() != 4) begin n_fail++; $display("FAIL incr_count: got %0d beats required 4", obs_addr.size()); end
    for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== exp_a[k] || obs_idx[k] !== 8'(k) || obs_last[k] !== (k == 3) || obs_id[k] !== 8'h11) begin
        n_fail++;
        $display("FAIL incr_beat[%0d]: got addr=%h idx=%0d last=%b id=%h required addr=%h idx=%0d last=%b id=11",
                 k, obs_addr[k], obs_idx[k], obs_last[k], obs_id[k], exp_a[k], k, (k == 3));
      end
    end
    if (acc_cyc.size() == 1 && obs_cyc.size() == 4) begin
      n_checks++;
      if (obs_cyc[0] != acc_cyc[0] + 1) begin
        n_fail++; $display("FAIL incr_latency: beat0 at cycle %0d required %0d", obs_cyc[0], acc_cyc[0] + 1);
      end
      n_checks++;
      if (obs_cyc[3] != obs_cyc[0] + 3) begin
        n_fail++; $display("FAIL incr_throughput: last beat at cycle %0d required %0d", obs_cyc[3], obs_cyc[0] + 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a[4];
    bit to;
    exp_a = '{32'h1018, 32'h1000, 32'h1008, 32'h1010};
    stim_q.delete();
    stim_q.push_back(mk(8'h22, 32'h1018, 8'd3, 3'd3, 2'd2));
    run_bursts(100, 0, 200, to);
    n_checks++;
    if (obs_addr.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d beats required 4", obs_addr.size()); end
    for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== exp_a[k] || obs_last[k] !== (k == 3)) begin
        n_fail++;
        $display("FAIL wrap_beat[%0d]: got addr=%h last=%b required addr=%h last=%b", k, obs_addr[k], obs_last[k], exp_a[k], (k == 3));
      end
    end
    n_checks++;
    if (err_cyc.size() != 0) begin n_fail++; $display("FAIL wrap_no_err: got %0d protoErr pulses required 0", err_cyc.size()); end
  endtask

  task automatic test_unaligned_fixed();
    logic [31:0] exp_a[6];
    bit to;
    exp_a = '{32'h1003, 32'h1004, 32'h1008, 32'h40, 32'h40, 32'h40};
    stim_q.delete();
    stim_q.push_back(mk(8'h33, 32'h1003, 8'd2, 3'd2, 2'd1));
    stim_q.push_back(mk(8'h44, 32'h40, 8'd2, 3'd2, 2'd0));
    run_bursts(100, 1, 300, to);
    n_checks++;
    if (obs_addr.size() != 6) begin n_fail++; $display("FAIL unal_fixed_count: got %0d beats required 6", obs_addr.size()); end
    for (int k = 0; k < 6 && k < obs_addr.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== exp_a[k] || obs_last[k] !== (k == 2 || k == 5)) begin
        n_fail++;
        $display("FAIL unal_fixed_beat[%0d]: got addr=%h last=%b required addr=%h last=%b",
                 k, obs_addr[k], obs_last[k], exp_a[k], (k == 2 || k == 5));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a[4];
    bit to;
    exp_a = '{32'h500, 32'h504, 32'h508, 32'h50C};
    for (int rep = 0; rep < 4; rep++) begin
      stim_q.delete();
      stim_q.push_back(mk(8'h55, 32'h500, 8'd3, 3'd2, 2'd1));
      run_bursts(45, 0, 400, to);
      n_checks++;
      if (obs_addr.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d beats required 4", obs_addr.size()); end
      for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
        n_checks++;
        if (obs_addr[k] !== exp_a[k] || obs_idx[k] !== 8'(k)) begin
          n_fail++;
          $display("FAIL bp_beat[%0d]: got addr=%h idx=%0d required addr=%h idx=%0d", k, obs_addr[k], obs_idx[k], exp_a[k], k);
        end
      end
      n_checks++;
      if (hold_viol != 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes while stalled required 0", hold_viol); end
    end
  endtask

  task automatic test_proto_err();
    logic [31:0] exp_a[9];
    bit to;
    exp_a = '{32'h2002, 32'h2004, 32'h2008, 32'h3010, 32'h3018, 32'h3020, 32'h4000, 32'h4008, 32'h40};
    stim_q.delete();
    stim_q.push_back(mk(8'h01, 32'h2002, 8'd2, 3'd2, 2'd3));
    stim_q.push_back(mk(8'h02, 32'h3010, 8'd2, 3'd3, 2'd2));
    stim_q.push_back(mk(8'h03, 32'h4000, 8'd1, 3'd7, 2'd1));
    stim_q.push_back(mk(8'h04, 32'h40,   8'd0, 3'd0, 2'd0));
    run_bursts(100, 1, 400, to);
    n_checks++;
    if (obs_addr.size() != 9) begin n_fail++; $display("FAIL perr_count: got %0d beats required 9", obs_addr.size()); end
    for (int k = 0; k < 9 && k < obs_addr.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== exp_a[k] || obs_last[k] !== (k == 2 || k == 5 || k == 7 || k == 8)) begin
        n_fail++;
        $display("FAIL perr_beat[%0d]: got addr=%h last=%b required addr=%h", k, obs_addr[k], obs_last[k], exp_a[k]);
      end
    end
    n_checks++;
    if (err_cyc.size() != 3 || acc_cyc.size() != 4) begin
      n_fail++; $display("FAIL perr_pulses: got %0d pulses/%0d accepts required 3/4", err_cyc.size(), acc_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (err_cyc[i] != acc_cyc[i] + 1) begin
          n_fail++; $display("FAIL perr_timing[%0d]: pulse at cycle %0d required %0d", i, err_cyc[i], acc_cyc[i] + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int gap;
`ifdef AXI_BEAT_ADDR_SKID_EN
    gap = 1;
`else
    gap = 2;
`endif
    stim_q.delete();
    stim_q.push_back(mk(8'h61, 32'h600, 8'd1, 3'd2, 2'd1));
    stim_q.push_back(mk(8'h62, 32'h700, 8'd1, 3'd2, 2'd1));
    run_bursts(100, 0, 200, to);
    n_checks++;
    if (obs_cyc.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d beats required 4", obs_cyc.size());
    end else begin
      n_checks++;
      if (obs_cyc[2] - obs_cyc[1] != gap) begin
        n_fail++; $display("FAIL b2b_gap: got spacing %0d required %0d", obs_cyc[2] - obs_cyc[1], gap);
      end
      n_checks++;
      if (obs_addr[2] !== 32'h700 || obs_id[2] !== 8'h62 || obs_addr[3] !== 32'h704) begin
        n_fail++; $display("FAIL b2b_second: got addr=%h id=%h addr=%h required 700 62 704", obs_addr[2], obs_id[2], obs_addr[3]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] wl[4];
    int exp_err_cyc[$];
    bit to;
    wl = '{8'd1, 8'd3, 8'd7, 8'd15};
    stim_q.delete();
    for (int i = 0; i < 30; i++) begin
      burst_t t;
      t.id    = 8'($urandom());
      t.addr  = $urandom();
      t.burst = 2'($urandom_range(0, 3));
      t.size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if (t.burst == 2'd2 && $urandom_range(0, 3) != 0) t.len = wl[$urandom_range(0, 3)];
      else t.len = 8'($urandom_range(0, 12));
      stim_q.push_back(t);
    end
    stim_q.push_back(mk(8'hFF, 32'hFFFF_FF80, 8'd255, 3'd0, 2'd1));
    build_expected();
    run_bursts(60, 1, 8000, to);
    n_checks++;
    if (to || obs_addr.size() != exp_addr.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d beats required %0d", obs_addr.size(), exp_addr.size());
    end
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== exp_addr[k] || obs_idx[k] !== exp_idx[k] || obs_last[k] !== exp_last[k] || obs_id[k] !== exp_id[k]) begin
        n_fail++;
        $display("FAIL rand_beat[%0d]: got addr=%h idx=%0d last=%b id=%h required addr=%h idx=%0d last=%b id=%h",
                 k, obs_addr[k], obs_idx[k], obs_last[k], obs_id[k], exp_addr[k], exp_idx[k], exp_last[k], exp_id[k]);
      end
    end
    foreach (exp_err[i]) if (exp_err[i] && i < acc_cyc.size()) exp_err_cyc.push_back(acc_cyc[i] + 1);
    n_checks++;
    if (err_cyc.size() != exp_err_cyc.size()) begin
      n_fail++; $display("FAIL rand_err_count: got %0d pulses required %0d", err_cyc.size(), exp_err_cyc.size());
    end
    for (int i = 0; i < exp_err_cyc.size() && i < err_cyc.size(); i++) begin
      n_checks++;
      if (err_cyc[i] != exp_err_cyc[i]) begin
        n_fail++; $display("FAIL rand_err_timing[%0d]: pulse at %0d required %0d", i, err_cyc[i], exp_err_cyc[i]);
      end
    end
    n_checks++;
    if (hold_viol != 0 || busy_bad != 0) begin
      n_fail++; $display("FAIL rand_hold_busy: got hold=%0d busy_low=%0d required 0 0", hold_viol, busy_bad);
    end
  endtask

  task automatic test_mid_reset();
    int waited = 0;
    bit seen_valid = 0;
    @(negedge aclk);
    axid = 8'h5A; axaddr = 32'h8000; axlen = 8'd7; axsize = 3'd2; axburst = 2'd1;
    axvalid = 1'b1; beatReady = 1'b1;
    while (!axready && waited < 20) begin @(negedge aclk); waited++; end
    n_checks++;
    if (axready !== 1'b1) begin n_fail++; $display("FAIL midrst_accept: axready got %b required 1", axready); end
    @(negedge aclk);
    axvalid = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (beatValid !== 1'b1) begin n_fail++; $display("FAIL midrst_active: beatValid got %b required 1", beatValid); end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (beatValid !== 1'b0 || busy !== 1'b0 || axready !== 1'b0 || beatAddr !== 32'd0 ||
        beatIndex !== 8'd0 || beatLast !== 1'b0 || beatId !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got v=%b busy=%b rdy=%b addr=%h idx=%0d last=%b id=%h required all zero",
               beatValid, busy, axready, beatAddr, beatIndex, beatLast, beatId);
    end
    @(negedge aclk);
    resetn = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      if (beatValid) seen_valid = 1;
    end
    n_checks++;
    if (seen_valid) begin n_fail++; $display("FAIL midrst_no_beats: got beatValid=1 after reset required 0"); end
    beatReady = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; axvalid = 1'b0; axid = 8'd0; axaddr = 32'd0; axlen = 8'd0;
    axsize = 3'd0; axburst = 2'd0; beatReady = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_unaligned_fixed();
    test_backpressure();
    test_proto_err();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
